// File: rtl/avr_uart_io.sv
// Data-bus stage behind the AVR core: passes SRAM traffic through and serves a
// FIFO-buffered UART (UBRRL 0x29, UCSRA 0x2B, UDR 0x2C) with zero wait states.
module avr_uart_io #(
  parameter int         FIFO_AW    = 2,
  parameter logic [7:0] UBRR_RESET = 8'd25
) (
  input  logic        clock,
  input  logic        locked,
  input  logic [15:0] address,
  input  logic [7:0]  wb,
  input  logic        w,
  input  logic        rd,
  input  logic [7:0]  sram_q,
  output logic        sram_we,
  output logic [7:0]  data,
  output logic        uart_tx,
  input  logic        uart_rx
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int PW    = FIFO_AW + 1;

  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

  logic            sel_ubrr, sel_ucsra, sel_udr, io_hit;
  logic            udr_wr, udr_rd, ubrr_wr, ucsra_wr;
  logic [7:0]      ubrr, baud_cnt, status, rd_mux;
  logic            baud_tick;
  logic            txc, fe, dor;
  logic            io_hit_q;
  logic [7:0]      io_rdata_q;

  logic [7:0]      tx_mem [DEPTH];
  logic [PW-1:0]   tx_wp, tx_rp;
  logic            tx_empty, tx_full, tx_push, tx_pop, tx_bit_end, txc_set;
  tx_state_t       tx_state;
  logic [3:0]      tx_cnt;
  logic [2:0]      tx_bit;
  logic [7:0]      tx_sh;

  logic [7:0]      rx_mem [DEPTH];
  logic [PW-1:0]   rx_wp, rx_rp;
  logic            rx_empty, rx_full, rx_push, rx_pop, rx_bit_end;
  logic            rx_sample, rx_done, fe_set, dor_set, rx_fall;
  logic            rx_p0, rx_p1, rx_p2;
  rx_state_t       rx_state;
  logic [3:0]      rx_cnt;
  logic [2:0]      rx_bit;
  logic [7:0]      rx_sh;

  assign sel_ubrr  = (address == 16'h0029);
  assign sel_ucsra = (address == 16'h002B);
  assign sel_udr   = (address == 16'h002C);
  assign io_hit    = sel_ubrr | sel_ucsra | sel_udr;

  assign udr_wr    = w & sel_udr;
  assign udr_rd    = rd & sel_udr;
  assign ubrr_wr   = w & sel_ubrr;
  assign ucsra_wr  = w & sel_ucsra;

  assign sram_we   = w & ~io_hit;
  assign data      = io_hit_q ? io_rdata_q : sram_q;

  assign tx_empty  = (tx_wp == tx_rp);
  assign tx_full   = (tx_wp[FIFO_AW] != tx_rp[FIFO_AW]) &&
                     (tx_wp[FIFO_AW-1:0] == tx_rp[FIFO_AW-1:0]);
  assign rx_empty  = (rx_wp == rx_rp);
  assign rx_full   = (rx_wp[FIFO_AW] != rx_rp[FIFO_AW]) &&
                     (rx_wp[FIFO_AW-1:0] == rx_rp[FIFO_AW-1:0]);

  assign status    = {~rx_empty, txc, ~tx_full, fe, dor, 3'b000};

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign tx_bit_end = baud_tick & (tx_cnt == 4'd15);
  assign tx_pop     = ~tx_empty & ((tx_state == T_IDLE) |
                                   ((tx_state == T_STOP) & tx_bit_end));
  assign tx_push    = udr_wr & (~tx_full | tx_pop);
  assign txc_set    = (tx_state == T_STOP) & tx_bit_end & tx_empty;

  assign rx_fall    = rx_p2 & ~rx_p1;
  assign rx_bit_end = baud_tick & (rx_cnt == 4'd15);
  assign rx_sample  = (rx_state == R_DATA) & rx_bit_end;
  assign rx_done    = (rx_state == R_STOP) & rx_bit_end;
  assign rx_pop     = udr_rd & ~rx_empty;
  assign rx_push    = rx_done & (~rx_full | rx_pop);
  assign dor_set    = rx_done & rx_full & ~rx_pop;
  assign fe_set     = rx_done & ~rx_p1;

  always_comb begin
    rd_mux = 8'h00;
    if (sel_ubrr)                 rd_mux = ubrr;
    else if (sel_ucsra)           rd_mux = status;
    else if (sel_udr && !rx_empty) rd_mux = rx_mem[rx_rp[FIFO_AW-1:0]];
  end

  // Bus stage: read data registered to line up with the SRAM's one-cycle latency
  always_ff @(posedge clock or negedge locked) begin
    if (!locked) begin
      io_hit_q   <= 1'b0;
      io_rdata_q <= 8'h00;
      ubrr       <= UBRR_RESET;
    end else begin
      io_hit_q   <= io_hit;
      io_rdata_q <= rd_mux;
      if (ubrr_wr) ubrr <= wb;
    end
  end

  // Baud stage: one tick per (UBRRL+1) clocks, new divisor picked up on reload
  always_ff @(posedge clock or negedge locked) begin
    if (!locked)        baud_cnt <= UBRR_RESET;
    else if (baud_tick) baud_cnt <= ubrr;
    else                baud_cnt <= baud_cnt - 8'd1;
  end
  assign baud_tick = (baud_cnt == 8'd0);

  always_ff @(posedge clock or negedge locked) begin
    if (!locked) begin
      tx_wp <= '0;
      tx_rp <= '0;
      rx_wp <= '0;
      rx_rp <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + PW'(1);
      if (tx_pop)  tx_rp <= tx_rp + PW'(1);
      if (rx_push) rx_wp <= rx_wp + PW'(1);
      if (rx_pop)  rx_rp <= rx_rp + PW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (tx_push) tx_mem[tx_wp[FIFO_AW-1:0]] <= wb;
    if (rx_push) rx_mem[rx_wp[FIFO_AW-1:0]] <= rx_sh;
  end

  // Transmit stage: start, 8 data bits LSB first, stop; chains frames without idle
  always_ff @(posedge clock or negedge locked) begin
    if (!locked) begin
      tx_state <= T_IDLE;
      tx_cnt   <= 4'd0;
      tx_bit   <= 3'd0;
      uart_tx  <= 1'b1;
      txc      <= 1'b0;
    end else begin
      case (tx_state)
        T_IDLE: begin
          if (!tx_empty) begin
            tx_state <= T_START;
            tx_cnt   <= 4'd0;
            uart_tx  <= 1'b0;
          end
        end
        T_START: begin
          if (baud_tick) begin
            if (tx_cnt == 4'd15) begin
              tx_state <= T_DATA;
              tx_cnt   <= 4'd0;
              tx_bit   <= 3'd0;
              uart_tx  <= tx_sh[0];
            end else begin
              tx_cnt <= tx_cnt + 4'd1;
            end
          end
        end
        T_DATA: begin
          if (baud_tick) begin
            if (tx_cnt == 4'd15) begin
              tx_cnt <= 4'd0;
              if (tx_bit == 3'd7) begin
                tx_state <= T_STOP;
                uart_tx  <= 1'b1;
              end else begin
                tx_bit  <= tx_bit + 3'd1;
                uart_tx <= tx_sh[1];
              end
            end else begin
              tx_cnt <= tx_cnt + 4'd1;
            end
          end
        end
        T_STOP: begin
          if (baud_tick) begin
            if (tx_cnt == 4'd15) begin
              tx_cnt <= 4'd0;
              if (!tx_empty) begin
                tx_state <= T_START;
                uart_tx  <= 1'b0;
              end else begin
                tx_state <= T_IDLE;
              end
            end else begin
              tx_cnt <= tx_cnt + 4'd1;
            end
          end
        end
        default: tx_state <= T_IDLE;
      endcase
      if (udr_wr)       txc <= 1'b0;
      else if (txc_set) txc <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (tx_pop)                              tx_sh <= tx_mem[tx_rp[FIFO_AW-1:0]];
    else if ((tx_state == T_DATA) && tx_bit_end) tx_sh <= {1'b0, tx_sh[7:1]};
  end

  // Receive stage: double-flop synchroniser plus a delayed copy for edge detect
  always_ff @(posedge clock or negedge locked) begin
    if (!locked) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
      rx_p2 <= 1'b1;
    end else begin
      rx_p0 <= uart_rx;
      rx_p1 <= rx_p0;
      rx_p2 <= rx_p1;
    end
  end

  always_ff @(posedge clock or negedge locked) begin
    if (!locked) begin
      rx_state <= R_IDLE;
      rx_cnt   <= 4'd0;
      rx_bit   <= 3'd0;
      fe       <= 1'b0;
      dor      <= 1'b0;
    end else begin
      case (rx_state)
        R_IDLE: begin
          if (rx_fall) begin
            rx_state <= R_START;
            rx_cnt   <= 4'd0;
          end
        end
        R_START: begin
          // Half a bit in: a line back high means the edge was a glitch
          if (baud_tick) begin
            if (rx_cnt == 4'd7) begin
              rx_cnt   <= 4'd0;
              rx_bit   <= 3'd0;
              rx_state <= rx_p1 ? R_IDLE : R_DATA;
            end else begin
              rx_cnt <= rx_cnt + 4'd1;
            end
          end
        end
        R_DATA: begin
          if (baud_tick) begin
            if (rx_cnt == 4'd15) begin
              rx_cnt <= 4'd0;
              if (rx_bit == 3'd7) rx_state <= R_STOP;
              else                rx_bit   <= rx_bit + 3'd1;
            end else begin
              rx_cnt <= rx_cnt + 4'd1;
            end
          end
        end
        R_STOP: begin
          if (baud_tick) begin
            if (rx_cnt == 4'd15) begin
              rx_cnt   <= 4'd0;
              rx_state <= R_IDLE;
            end else begin
              rx_cnt <= rx_cnt + 4'd1;
            end
          end
        end
        default: rx_state <= R_IDLE;
      endcase
      if (ucsra_wr && wb[4]) fe  <= 1'b0;
      if (fe_set)            fe  <= 1'b1;
      if (ucsra_wr && wb[3]) dor <= 1'b0;
      if (dor_set)           dor <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (rx_sample) rx_sh <= {rx_p1, rx_sh[7:1]};
  end

endmodule

// File: tb/tb_avr_uart_io.sv
// Directed bench for avr_uart_io: bus decode, TX framing/FIFO, RX framing,
// status flags and asynchronous reset behaviour with UBRRL=0 (16 clocks/bit).
module tb_avr_uart_io;

  logic        clock   = 1'b0;
  logic        locked  = 1'b0;
  logic [15:0] address = 16'h0100;
  logic [7:0]  wb      = 8'h00;
  logic        w       = 1'b0;
  logic        rd      = 1'b0;
  logic [7:0]  sram_q  = 8'hE7;
  logic        sram_we;
  logic [7:0]  data;
  logic        uart_tx;
  logic        uart_rx = 1'b1;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  always #5 clock = ~clock;

  avr_uart_io #(.FIFO_AW(2), .UBRR_RESET(8'd25)) dut (
    .clock   (clock),
    .locked  (locked),
    .address (address),
    .wb      (wb),
    .w       (w),
    .rd      (rd),
    .sram_q  (sram_q),
    .sram_we (sram_we),
    .data    (data),
    .uart_tx (uart_tx),
    .uart_rx (uart_rx)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic store(input logic [15:0] a, input logic [7:0] v);
    @(negedge clock);
    address = a; wb = v; w = 1'b1;
    @(posedge clock); #1;
    w = 1'b0; address = 16'h0100;
  endtask

  task automatic load_chk(input string tag, input logic [15:0] a, input logic [7:0] exp);
    logic [7:0] v;
    @(negedge clock);
    address = a; rd = 1'b1;
    @(posedge clock); #1;
    rd = 1'b0; address = 16'h0100;
    v = data;
    chk(tag, {8'h00, v}, {8'h00, exp});
  endtask

  // Waits for a start bit, then samples each bit near its middle
  task automatic tx_frame(input string tag, input logic [7:0] exp, output int gap);
    logic [9:0] f;
    gap = 0;
    while (uart_tx !== 1'b0 && gap < 400) begin
      @(negedge clock);
      gap++;
    end
    chk({tag, "_start"}, {15'd0, uart_tx}, 16'd0);
    repeat (8) @(negedge clock);
    f[0] = uart_tx;
    for (int i = 1; i < 10; i++) begin
      repeat (16) @(negedge clock);
      f[i] = uart_tx;
    end
    chk({tag, "_frame"}, {6'd0, f}, {6'd0, 1'b1, exp, 1'b0});
  endtask

  task automatic rx_send(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      uart_rx = f[i];
      repeat (15) @(negedge clock);
    end
    @(negedge clock);
    uart_rx = 1'b1;
  endtask

  task automatic count_tx_low(input string tag, input int cycles);
    int lows;
    lows = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clock);
      if (uart_tx !== 1'b1) lows++;
    end
    chk(tag, 16'(lows), 16'd0);
  endtask

  initial begin
    int         g;
    logic [7:0] bq [4];
    bq[0] = 8'h11; bq[1] = 8'h22; bq[2] = 8'h33; bq[3] = 8'h44;

    // reset state
    repeat (3) @(negedge clock);
    chk("rst_uart_tx", {15'd0, uart_tx}, 16'd1);
    chk("rst_sram_we", {15'd0, sram_we}, 16'd0);
    chk("rst_data",    {8'd0, data},     16'h00E7);
    @(negedge clock);
    locked = 1'b1;
    repeat (2) @(negedge clock);
    load_chk("ubrr_rst",  16'h0029, 8'h19);
    load_chk("ucsra_rst", 16'h002B, 8'h20);

    store(16'h0029, 8'h00);
    repeat (40) @(negedge clock);
    load_chk("ubrr_wr", 16'h0029, 8'h00);

    // single byte 0x55
    store(16'h002C, 8'h55);
    tx_frame("tx55", 8'h55, g);
    repeat (10) @(negedge clock);
    load_chk("txc_set", 16'h002B, 8'h60);

    // six consecutive stores: one goes to the shifter, four fill the FIFO, last dropped
    store(16'h002C, 8'hA0);
    store(16'h002C, 8'h11);
    store(16'h002C, 8'h22);
    store(16'h002C, 8'h33);
    store(16'h002C, 8'h44);
    store(16'h002C, 8'h99);
    load_chk("udre_full", 16'h002B, 8'h00);
    tx_frame("txA0", 8'hA0, g);
    for (int i = 0; i < 4; i++) begin
      tx_frame("txq", bq[i], g);
      chk("tx_gap", (g <= 8) ? 16'd1 : 16'd0, 16'd1);
    end
    count_tx_low("tx_dropped", 300);
    load_chk("txc_after_burst", 16'h002B, 8'h60);

    // receive one frame
    rx_send(8'hA3, 1'b1);
    repeat (4) @(negedge clock);
    load_chk("rxc_set",   16'h002B, 8'hE0);
    load_chk("rx_a3",     16'h002C, 8'hA3);
    load_chk("rxc_clr",   16'h002B, 8'h60);
    load_chk("udr_empty", 16'h002C, 8'h00);

    // overrun
    rx_send(8'h01, 1'b1);
    rx_send(8'h02, 1'b1);
    rx_send(8'h03, 1'b1);
    rx_send(8'h04, 1'b1);
    rx_send(8'h05, 1'b1);
    repeat (4) @(negedge clock);
    load_chk("dor_set", 16'h002B, 8'hE8);
    store(16'h002B, 8'h08);
    load_chk("dor_clr", 16'h002B, 8'hE0);
    load_chk("rx_q0", 16'h002C, 8'h01);
    load_chk("rx_q1", 16'h002C, 8'h02);
    load_chk("rx_q2", 16'h002C, 8'h03);
    load_chk("rx_q3", 16'h002C, 8'h04);
    load_chk("rx_drained", 16'h002B, 8'h60);

    // framing error
    rx_send(8'h5A, 1'b0);
    repeat (4) @(negedge clock);
    load_chk("fe_set", 16'h002B, 8'hF0);
    load_chk("rx_5a",  16'h002C, 8'h5A);
    store(16'h002B, 8'h10);
    load_chk("fe_clr", 16'h002B, 8'h60);

    // 4-clock glitch, then a good frame
    @(negedge clock);
    uart_rx = 1'b0;
    repeat (4) @(negedge clock);
    uart_rx = 1'b1;
    repeat (60) @(negedge clock);
    load_chk("glitch_nopush", 16'h002B, 8'h60);
    rx_send(8'h3C, 1'b1);
    repeat (4) @(negedge clock);
    load_chk("rx_after_glitch", 16'h002C, 8'h3C);

    // reset in the middle of a transmitted frame
    store(16'h002C, 8'h00);
    store(16'h002C, 8'h77);
    repeat (40) @(negedge clock);
    chk("tx_mid_frame", {15'd0, uart_tx}, 16'd0);
    locked = 1'b0;
    #1;
    chk("rst_async_tx", {15'd0, uart_tx}, 16'd1);
    repeat (2) @(negedge clock);
    locked = 1'b1;
    repeat (2) @(negedge clock);
    load_chk("rst2_ucsra", 16'h002B, 8'h20);
    load_chk("rst2_ubrr",  16'h0029, 8'h19);
    load_chk("rst2_udr",   16'h002C, 8'h00);
    count_tx_low("rst2_tx_idle", 100);

    // SRAM pass-through
    @(negedge clock);
    address = 16'h0100; wb = 8'h12; w = 1'b1;
    #1;
    chk("sram_we_mem", {15'd0, sram_we}, 16'd1);
    @(negedge clock);
    address = 16'h002B; wb = 8'h00;
    #1;
    chk("sram_we_io", {15'd0, sram_we}, 16'd0);
    @(posedge clock); #1;
    w = 1'b0; address = 16'h0100;
    sram_q = 8'h3D;
    load_chk("unmapped_io", 16'h002A, 8'h3D);
    load_chk("sram_read",   16'h0100, 8'h3D);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
